// File: rtl/seq_alu_if.sv
// Handshake and operand/result bundle between an op source and seq_alu.
// The source drives the master side; the ALU sits on the slave side.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             IN_VALID;
  logic             IN_READY;
  logic             XIN;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       S;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] F;
  logic             Z;
  logic             V;
  logic             C;

  modport master (
    output IN_VALID, XIN, A, B, S, OUT_READY,
    input  IN_READY, OUT_VALID, F, Z, V, C
  );

  modport slave (
    input  IN_VALID, XIN, A, B, S, OUT_READY,
    output IN_READY, OUT_VALID, F, Z, V, C
  );
endinterface

// File: rtl/seq_alu.sv
// Registered WIDTH-bit ALU with valid/ready handshakes on both sides and a
// multi-cycle shift-add unsigned multiply; flags match the old 4-bit ALU.
module seq_alu #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input logic      CLK,
  input logic      RST_N,
  seq_alu_if.slave bus
);
  localparam int MSB = WIDTH - 1;
  localparam int SH  = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH);

  typedef enum logic {IDLE, MUL} state_t;

  state_t             r_state, w_stateNext;
  logic [CW-1:0]      r_cnt, w_cntNext;
  logic [2*WIDTH-1:0] r_prod, w_prodNext;
  logic [2*WIDTH-1:0] r_mcand, w_mcandNext;
  logic [2*WIDTH-1:0] w_partial;
  logic [WIDTH-1:0]   r_mplier, w_mplierNext;
  logic [WIDTH-1:0]   r_f, w_fNext;
  logic               r_z, w_zNext;
  logic               r_v, w_vNext;
  logic               r_c, w_cNext;
  logic               r_outValid, w_outValidNext;
  logic               r_rstDone;
  logic               w_accept;
  logic               w_isMul;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH-1:0]   w_res;
  logic               w_resV;
  logic               w_resC;

  // r_rstDone keeps IN_READY low until the first edge after reset release.
  assign bus.IN_READY = r_rstDone && (r_state == IDLE) && (!r_outValid || bus.OUT_READY);
  assign w_accept     = bus.IN_VALID && bus.IN_READY;
  assign w_isMul      = MUL_EN && (bus.S == 3'b100);

  assign w_sum     = {1'b0, bus.A} + {1'b0, bus.B} + (WIDTH+1)'(bus.XIN);
  assign w_diff    = {1'b0, bus.A} + {1'b0, ~bus.B} + (WIDTH+1)'(!bus.XIN);
  assign w_shl     = {1'b0, bus.A} << bus.B[SH-1:0];
  assign w_partial = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

  always_comb begin
    w_res  = '0;
    w_resV = 1'b0;
    w_resC = 1'b0;
    case (bus.S)
      3'b000: begin
        w_res  = w_sum[MSB:0];
        w_resC = w_sum[WIDTH];
        w_resV = (bus.A[MSB] == bus.B[MSB]) && (w_sum[MSB] != bus.A[MSB]);
      end
      3'b001: begin
        w_res  = w_diff[MSB:0];
        w_resC = w_diff[WIDTH];
        w_resV = (bus.A[MSB] != bus.B[MSB]) && (w_diff[MSB] != bus.A[MSB]);
      end
      3'b010: w_res = bus.A & bus.B;
      3'b011: w_res = bus.A | bus.B;
      3'b100: w_res = '0;
      3'b101: begin
        // Bit WIDTH of the widened shift is the last bit pushed out of A.
        w_res  = w_shl[MSB:0];
        w_resC = w_shl[WIDTH];
      end
      3'b110: w_res = bus.A ^ bus.B;
      3'b111: w_res = WIDTH'($signed(bus.A) < $signed(bus.B));
    endcase
  end

  always_comb begin
    w_stateNext    = r_state;
    w_cntNext      = r_cnt;
    w_prodNext     = r_prod;
    w_mcandNext    = r_mcand;
    w_mplierNext   = r_mplier;
    w_fNext        = r_f;
    w_zNext        = r_z;
    w_vNext        = r_v;
    w_cNext        = r_c;
    w_outValidNext = r_outValid;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_isMul) begin
            w_stateNext    = MUL;
            w_cntNext      = CW'(WIDTH - 1);
            w_prodNext     = '0;
            w_mcandNext    = {{WIDTH{1'b0}}, bus.A};
            w_mplierNext   = bus.B;
            w_outValidNext = 1'b0;
          end else begin
            w_fNext        = w_res;
            w_zNext        = (w_res == '0);
            w_vNext        = w_resV;
            w_cNext        = w_resC;
            w_outValidNext = 1'b1;
          end
        end else if (r_outValid && bus.OUT_READY) begin
          w_outValidNext = 1'b0;
        end
      end
      MUL: begin
        w_prodNext   = w_partial;
        w_mcandNext  = r_mcand << 1;
        w_mplierNext = r_mplier >> 1;
        w_cntNext    = r_cnt - CW'(1);
        if (r_cnt == '0) begin
          w_stateNext    = IDLE;
          w_fNext        = w_partial[MSB:0];
          w_zNext        = (w_partial[MSB:0] == '0);
          w_vNext        = 1'b0;
          w_cNext        = |w_partial[2*WIDTH-1:WIDTH];
          w_outValidNext = 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_prod     <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_f        <= '0;
      r_z        <= 1'b0;
      r_v        <= 1'b0;
      r_c        <= 1'b0;
      r_outValid <= 1'b0;
      r_rstDone  <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_cnt      <= w_cntNext;
      r_prod     <= w_prodNext;
      r_mcand    <= w_mcandNext;
      r_mplier   <= w_mplierNext;
      r_f        <= w_fNext;
      r_z        <= w_zNext;
      r_v        <= w_vNext;
      r_c        <= w_cNext;
      r_outValid <= w_outValidNext;
      r_rstDone  <= 1'b1;
    end
  end

  assign bus.OUT_VALID = r_outValid;
  assign bus.F         = r_f;
  assign bus.Z         = r_z;
  assign bus.V         = r_v;
  assign bus.C         = r_c;
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the team's 4-bit combinational ALU: WIDTH-bit operands, 3-bit op select, Z/V/C flags.
- Adds valid/ready handshakes on input and output, registered results, and a multi-cycle shift-add unsigned multiply.
- Sits between an operand/instruction source and a result consumer. The flag semantics of the combinational ALU are kept for the shared op codes.

Parameters:
- WIDTH, 8, operand/result width in bits; minimum 2.
- MUL_EN, 1, 1 = op 100 is a multi-cycle multiply; 0 = op 100 completes in 1 cycle with F=0, C=0, V=0, Z=1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  operand/op presented.
- IN_READY  out  1  block can accept an op this cycle.
- XIN  in  1  carry/borrow in; used by ADD and SUB only.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- S  in  3  op select.
- OUT_VALID  out  1  result registers hold a valid result.
- OUT_READY  in  1  consumer takes the result this cycle.
- F  out  WIDTH  result.
- Z  out  1  zero flag: F == 0, for every op.
- V  out  1  signed overflow flag.
- C  out  1  carry flag.

Behaviour:
- Reset (RST_N low, asynchronous, effective immediately):
  - FSM returns to IDLE; multiply counter and partial product cleared.
  - OUT_VALID=0, F=0, Z=0, V=0, C=0, IN_READY=0 while reset is held.
  - After release, IN_READY=1 from the first clock edge onward.
- Accept: a transfer occurs when IN_VALID && IN_READY on a rising edge. A, B, S and XIN are sampled only at accept.
- IN_READY = (state == IDLE) && (!OUT_VALID || OUT_READY). An op is therefore accepted in the same cycle the previous result drains.
- Ops (S), with WIDTH-bit wrap-around:
  - 000 ADD:
    - F = A+B+XIN.
    - C = carry out of bit WIDTH-1.
    - V = (A[msb]==B[msb]) && (F[msb]!=A[msb]).
  - 001 SUB:
    - F = A-B-XIN, computed as A + ~B + !XIN.
    - C = carry out of that sum (1 = no borrow).
    - V = (A[msb]!=B[msb]) && (F[msb]!=A[msb]).
  - 010 AND; 011 OR: C=0, V=0.
  - 100 MUL (MUL_EN=1):
    - Unsigned A*B. F = low WIDTH bits.
    - C = 1 if the high WIDTH bits are nonzero; V=0.
  - 101 SHL:
    - F = A << B[SH-1:0], where SH = ceil(log2(WIDTH)).
    - C = last bit shifted out; C=0 for a shift of 0. V=0.
  - 110 XOR: C=0, V=0.
  - 111 SLT: F = 1 if signed A < signed B, else 0. C=0, V=0.
- Latency:
  - Single-cycle ops: result registered on the accept edge; OUT_VALID=1 in the next cycle.
  - MUL: state IDLE -> MUL on accept. One shift-add iteration per cycle for WIDTH cycles; counter runs WIDTH-1 down to 0. The final iteration writes F/flags and sets OUT_VALID, then returns to IDLE.
  - MUL result: OUT_VALID first seen WIDTH cycles after the accept edge.
  - IN_READY=0 for the whole MUL state.
- Output hold:
  - While OUT_VALID && !OUT_READY, F/Z/V/C/OUT_VALID are stable.
  - On OUT_READY with no new accept, OUT_VALID clears next edge; F and flags keep their last values.
- Simultaneous drain and accept: the new result overwrites the registers and OUT_VALID stays 1.
- IN_VALID while IN_READY=0 is ignored; the source must hold it.
- Reset during MUL aborts the op; no result is produced.

Test Plan (WIDTH=8, MUL_EN=1 unless noted):
1. ADD A=0x7F B=0x01 XIN=0 -> F=0x80, V=1, C=0, Z=0; OUT_VALID the cycle after accept. Then ADD A=0xFF B=0x00 XIN=1 -> F=0x00, Z=1, C=1, V=0.
2. SUB A=0x00 B=0x01 XIN=0 -> F=0xFF, C=0, V=0. SUB A=0x80 B=0x01 XIN=0 -> F=0x7F, V=1, C=1.
3. MUL A=0x12 B=0x10 -> F=0x20, C=1, V=0, Z=0; OUT_VALID exactly 8 cycles after accept; IN_READY=0 throughout. MUL A=0x00 B=0x35 -> F=0, Z=1, C=0. With MUL_EN=0, MUL A=0x12 B=0x10 -> F=0, Z=1, C=0, V=0 one cycle after accept.
4. Logic/shift/compare:
   - AND 0xF0&0x3C=0x30; OR 0xF0|0x0C=0xFC.
   - XOR A=0xFF B=0xCC -> F=0x33; XOR A=0xCC B=0xCC -> Z=1.
   - SHL A=0x81 B=0x01 -> F=0x02, C=1; SHL A=0x81 B=0x00 -> F=0x81, C=0.
   - SLT A=0xFC B=0x03 -> F=0x01; SLT A=0x03 B=0xFC -> F=0x00, Z=1.
5. Backpressure: OUT_READY=0 for 3 cycles after a result -> F and flags stable, IN_READY=0. Raise OUT_READY with IN_VALID=1 -> new op accepted that cycle, OUT_VALID stays 1, new F next cycle.
6. Reset mid-MUL: assert RST_N=0 four cycles into a MUL -> OUT_VALID, F and flags go to 0 without waiting for a clock edge. After release, IN_READY=1 and a fresh ADD completes normally.
